// File: rtl/rca_pkg.sv
// Shared width and operand type for the 4-bit ripple-carry adder.
package rca_pkg;

  localparam int RCA_WIDTH = 4;

  typedef logic [RCA_WIDTH-1:0] rca_word_t;

endpackage

// File: rtl/rca_full_adder.sv
// One-bit full adder cell; the adder carry chain is built from these.
module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/ripple_carry_adder_4bit.sv
// 4-bit ripple-carry adder with combinational and registered outputs.
// Define RCA_OVERFLOW_EN to add the signed overflow outputs ovf/ovf_q.
module ripple_carry_adder_4bit
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  input  rca_word_t a,
  input  rca_word_t b,
  input  logic      cin,
  output rca_word_t sum,
  output logic      cout,
  output rca_word_t sum_q,
  output logic      cout_q
`ifdef RCA_OVERFLOW_EN
  ,
  output logic      ovf,
  output logic      ovf_q
`endif
);

  if (WIDTH != RCA_WIDTH) begin : g_bad_width
    $error("ripple_carry_adder_4bit: WIDTH must be 4");
  end

  logic [RCA_WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < RCA_WIDTH; i++) begin : g_fa
    rca_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[RCA_WIDTH];

`ifdef RCA_OVERFLOW_EN
  // Carry into and out of the sign bit differ exactly on signed overflow.
  assign ovf = c[RCA_WIDTH-1] ^ c[RCA_WIDTH];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef RCA_OVERFLOW_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
`ifdef RCA_OVERFLOW_EN
      ovf_q  <= ovf;
`endif
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder_4bit.sv
// Self-checking bench for ripple_carry_adder_4bit: corners, sweep,
// random registered traffic, async reset, optional overflow outputs.
module tb_ripple_carry_adder_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       cout;
  logic [3:0] sum_q;
  logic       cout_q;
`ifdef RCA_OVERFLOW_EN
  logic       ovf;
  logic       ovf_q;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ripple_carry_adder_4bit dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout),
    .sum_q  (sum_q),
    .cout_q (cout_q)
`ifdef RCA_OVERFLOW_EN
    ,
    .ovf    (ovf),
    .ovf_q  (ovf_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic, 5-bit result.
  function automatic logic [4:0] ref_add(input int x, input int y,
                                         input int ci);
    int t;
    t = x + y + ci;
    return t[4:0];
  endfunction

  // Reference: signed sum outside the 4-bit two's-complement range.
  function automatic logic ref_ovf(input int x, input int y,
                                   input int ci);
    int sx, sy, t;
    sx = (x >= 8) ? x - 16 : x;
    sy = (y >= 8) ? y - 16 : y;
    t  = sx + sy + ci;
    return (t > 7) || (t < -8);
  endfunction

  task automatic drive(input int x, input int y, input int ci);
    a   = x[3:0];
    b   = y[3:0];
    cin = ci[0];
  endtask

  task automatic check_comb(input string tag, input int x,
                            input int y, input int ci);
    logic [4:0] e;
    e = ref_add(x, y, ci);
    check(tag, {27'd0, cout, sum}, {27'd0, e});
`ifdef RCA_OVERFLOW_EN
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, ref_ovf(x, y, ci)});
`endif
  endtask

  int corner [9][5] = '{
    '{0, 0, 0, 'h0, 0}, '{0, 0, 1, 'h1, 0},
    '{15, 0, 0, 'hF, 0}, '{15, 15, 0, 'hE, 1},
    '{15, 15, 1, 'hF, 1}, '{7, 1, 0, 'h8, 0},
    '{15, 1, 0, 'h0, 1}, '{10, 5, 0, 'hF, 0},
    '{8, 8, 0, 'h0, 1}
  };

  initial begin
    logic [4:0] e;
    logic       eo;
    int         x, y, ci;

    rst = 1'b1;
    drive(0, 0, 0);
    #3;
    check("reset_sum_q", {28'd0, sum_q}, 32'd0);
    check("reset_cout_q", {31'd0, cout_q}, 32'd0);
`ifdef RCA_OVERFLOW_EN
    check("reset_ovf_q", {31'd0, ovf_q}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Corner table: hard-coded expected sum/cout.
    foreach (corner[k]) begin
      @(negedge clk);
      drive(corner[k][0], corner[k][1], corner[k][2]);
      #1;
      check($sformatf("corner%0d_sum", k),
            {28'd0, sum}, corner[k][3]);
      check($sformatf("corner%0d_cout", k),
            {31'd0, cout}, corner[k][4]);
    end

`ifdef RCA_OVERFLOW_EN
    @(negedge clk); drive(7, 1, 0); #1;
    check("ovf_7_1", {31'd0, ovf}, 32'd1);
    @(negedge clk); drive(8, 8, 0); #1;
    check("ovf_8_8", {31'd0, ovf}, 32'd1);
    @(posedge clk); #1;
    check("ovf_q_8_8", {31'd0, ovf_q}, 32'd1);
    @(negedge clk); drive(15, 1, 0); #1;
    check("ovf_f_1", {31'd0, ovf}, 32'd0);
    @(posedge clk); #1;
    check("ovf_q_f_1", {31'd0, ovf_q}, 32'd0);
`endif

    // Exhaustive sweep, 10 ns per vector.
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      drive(i & 15, (i >> 4) & 15, (i >> 8) & 1);
      #1;
      check_comb($sformatf("sweep%0d", i),
                 i & 15, (i >> 4) & 15, (i >> 8) & 1);
    end

    // Registered path: 3+4+1 = 8.
    @(negedge clk);
    drive(3, 4, 1);
    @(posedge clk); #1;
    check("reg_sum_q", {28'd0, sum_q}, 32'd8);
    check("reg_cout_q", {31'd0, cout_q}, 32'd0);
    drive(15, 15, 1);
    #2;
    check("reg_hold_sum_q", {28'd0, sum_q}, 32'd8);
    check("reg_new_sum", {27'd0, cout, sum}, 32'h1F);
    @(posedge clk); #1;
    check("reg_next_sum_q", {27'd0, cout_q, sum_q}, 32'h1F);

    // Async reset between edges.
    @(negedge clk);
    drive(3, 4, 1);
    @(posedge clk); #1;
    check("pre_rst_sum_q", {28'd0, sum_q}, 32'd8);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_sum_q", {28'd0, sum_q}, 32'd0);
    check("async_rst_cout_q", {31'd0, cout_q}, 32'd0);
    check("async_rst_sum", {27'd0, cout, sum}, 32'd8);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_hold", {28'd0, sum_q}, 32'd0);
    @(posedge clk); #1;
    check("rst_reload_sum_q", {28'd0, sum_q}, 32'd8);

    // Random traffic through the registered outputs.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      x  = int'($urandom_range(15));
      y  = int'($urandom_range(15));
      ci = int'($urandom_range(1));
      drive(x, y, ci);
      e  = ref_add(x, y, ci);
      eo = ref_ovf(x, y, ci);
      #1;
      check_comb($sformatf("rand%0d", i), x, y, ci);
      @(posedge clk); #1;
      check($sformatf("rand%0d_q", i),
            {27'd0, cout_q, sum_q}, {27'd0, e});
`ifdef RCA_OVERFLOW_EN
      check($sformatf("rand%0d_ovf_q", i),
            {31'd0, ovf_q}, {31'd0, eo});
`else
      if (eo === 1'bx) check("rand_ovf_model", 32'd0, 32'd1);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
